// File: rtl/genevr_csr_bank.sv
`default_nettype none
// ============================================================================
// Module   : genevr_csr_bank
// Purpose  : Control/status register bank on the packet-generator register
//            bus. Holds NUM_RW_REGS software control words, per-channel
//            sticky completion flags (write-1-to-clear) and per-channel
//            saturating completion-event counters.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            reg_req_in          - request level, held until ack
//            reg_rd_wr_L_in      - 1 = read, 0 = write
//            reg_addr_in         - byte address (tag | word index | 2'b00)
//            reg_wr_data         - write data
//            reg_ack_out         - one-cycle acknowledge
//            reg_rd_data         - read data, valid while reg_ack_out = 1
//            rw_regs             - flat control words, word i at [32*i+31:32*i]
//            done_in, busy_in    - per-channel completion pulse / busy level
//            irq_out             - only with GENEVR_CSR_IRQ_EN defined
// Options  : GENEVR_CSR_IRQ_EN - adds IRQ mask at word 31 and irq_out.
// Revision : 1.0 - initial release
// ============================================================================
module genevr_csr_bank #(
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 26,
   parameter int REG_ADDR_WIDTH = 8,
   parameter logic [AXI_ADDR_WIDTH-REG_ADDR_WIDTH-1:0] BLOCK_ADDR = 18'h04005,
   parameter int NUM_RW_REGS    = 8,
   parameter int NUM_CH         = 3,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          reg_req_in,
   input  logic                          reg_rd_wr_L_in,
   input  logic [AXI_ADDR_WIDTH-1:0]     reg_addr_in,
   input  logic [AXI_DATA_WIDTH-1:0]     reg_wr_data,
   output logic                          reg_ack_out,
   output logic [AXI_DATA_WIDTH-1:0]     reg_rd_data,
   output logic [32*NUM_RW_REGS-1:0]     rw_regs,
   input  logic [NUM_CH-1:0]             done_in,
   input  logic [NUM_CH-1:0]             busy_in
`ifdef GENEVR_CSR_IRQ_EN
   ,
   output logic                          irq_out
`endif
);

   localparam int WIDX_W = REG_ADDR_WIDTH - 2;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
   localparam logic [WIDX_W-1:0] STS_BASE = WIDX_W'(32);
   localparam logic [WIDX_W-1:0] CNT_BASE = WIDX_W'(48);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_ACK  = 1'b1;

   logic [0:0]                        state;
   logic [NUM_RW_REGS-1:0][31:0]      rw_q;
   logic [NUM_CH-1:0]                 sticky_q;
   logic [NUM_CH-1:0][CNT_WIDTH-1:0]  cnt_q;

   logic [WIDX_W-1:0] word_idx;
   logic              tag_hit;
   logic              accept;
   logic              wr_en;
   logic [31:0]       rd_mux;
   logic [NUM_CH-1:0] sts_w1c;
   logic [NUM_CH-1:0] cnt_clr;
   logic              unused_addr_bits;

   assign word_idx  = reg_addr_in[REG_ADDR_WIDTH-1:2];
   assign tag_hit   = (reg_addr_in[AXI_ADDR_WIDTH-1:REG_ADDR_WIDTH] == BLOCK_ADDR);
   // Requests seen during the ACK cycle are ignored; the requester keeps
   // req high only until it sees ack, so this never double-accepts.
   assign accept    = (state == ST_IDLE) && reg_req_in && tag_hit;
   assign wr_en     = accept && !reg_rd_wr_L_in;
   assign unused_addr_bits = &{1'b0, reg_addr_in[1:0]};

   assign reg_ack_out = (state == ST_ACK);
   assign rw_regs     = rw_q;

`ifdef GENEVR_CSR_IRQ_EN
   localparam logic [WIDX_W-1:0] MASK_IDX = WIDX_W'(31);
   logic [NUM_CH-1:0] mask_q;
`endif

   // Read mux: unmapped indices fall through to the DEADBEEF marker.
   always_comb begin
      rd_mux = 32'hDEADBEEF;
      for (int i = 0; i < NUM_RW_REGS; i++) begin
         if (word_idx == WIDX_W'(i)) rd_mux = rw_q[i];
      end
      for (int ch = 0; ch < NUM_CH; ch++) begin
         if (word_idx == STS_BASE + WIDX_W'(ch))
            rd_mux = {30'b0, busy_in[ch], sticky_q[ch]};
         if (word_idx == CNT_BASE + WIDX_W'(ch))
            rd_mux = 32'(cnt_q[ch]);
      end
`ifdef GENEVR_CSR_IRQ_EN
      if (word_idx == MASK_IDX) rd_mux = 32'(mask_q);
`endif
   end

   // Per-channel write decode for the status and counter windows.
   always_comb begin
      sts_w1c = '0;
      cnt_clr = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         sts_w1c[ch] = wr_en && (word_idx == STS_BASE + WIDX_W'(ch)) && reg_wr_data[0];
         cnt_clr[ch] = wr_en && (word_idx == CNT_BASE + WIDX_W'(ch));
      end
   end

   // Bus handshake FSM and read-data register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         reg_rd_data <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state       <= ST_ACK;
                  reg_rd_data <= reg_rd_wr_L_in ? rd_mux : 32'h0;
               end else begin
                  reg_rd_data <= '0;
               end
            end
            ST_ACK:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Software control words.
   always_ff @(posedge clk) begin
      if (reset) begin
         rw_q <= '0;
      end else if (wr_en) begin
         for (int i = 0; i < NUM_RW_REGS; i++) begin
            if (word_idx == WIDX_W'(i)) rw_q[i] <= reg_wr_data;
         end
      end
   end

   // Sticky flags and counters. A completion in the same cycle as a clear
   // wins: the sticky stays set and the counter restarts at 1.
   always_ff @(posedge clk) begin
      if (reset) begin
         sticky_q <= '0;
         cnt_q    <= '0;
      end else begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if (done_in[ch])
               sticky_q[ch] <= 1'b1;
            else if (sts_w1c[ch])
               sticky_q[ch] <= 1'b0;

            if (cnt_clr[ch])
               cnt_q[ch] <= CNT_WIDTH'(done_in[ch]);
            else if (done_in[ch] && (cnt_q[ch] != CNT_MAX))
               cnt_q[ch] <= cnt_q[ch] + CNT_WIDTH'(1);
         end
      end
   end

`ifdef GENEVR_CSR_IRQ_EN
   // Mask register and registered interrupt (one cycle after sticky sets).
   always_ff @(posedge clk) begin
      if (reset) begin
         mask_q  <= '0;
         irq_out <= 1'b0;
      end else begin
         if (wr_en && (word_idx == MASK_IDX)) mask_q <= reg_wr_data[NUM_CH-1:0];
         irq_out <= |(sticky_q & mask_q);
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_genevr_csr_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_genevr_csr_bank
// Purpose  : Self-checking bench for genevr_csr_bank (CNT_WIDTH = 4).
//            A driver issues one bus cycle per clock, updates a behavioural
//            model of the register map and queues the expected response;
//            a monitor pops and compares after every clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_genevr_csr_bank;

   localparam int NRW    = 8;
   localparam int NUM_CH = 3;
   localparam int CNT_W  = 4;
   localparam int CMAX   = (1 << CNT_W) - 1;
   localparam logic [17:0] TAG = 18'h04005;

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic                  reg_req_in = 1'b0;
   logic                  reg_rd_wr_L_in = 1'b1;
   logic [25:0]           reg_addr_in = '0;
   logic [31:0]           reg_wr_data = '0;
   logic                  reg_ack_out;
   logic [31:0]           reg_rd_data;
   logic [32*NRW-1:0]     rw_regs;
   logic [NUM_CH-1:0]     done_in = '0;
   logic [NUM_CH-1:0]     busy_in = '0;
`ifdef GENEVR_CSR_IRQ_EN
   logic                  irq_out;
`endif

   always #5 clk = ~clk;

   genevr_csr_bank #(
      .NUM_RW_REGS (NRW),
      .NUM_CH      (NUM_CH),
      .CNT_WIDTH   (CNT_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .reg_req_in     (reg_req_in),
      .reg_rd_wr_L_in (reg_rd_wr_L_in),
      .reg_addr_in    (reg_addr_in),
      .reg_wr_data    (reg_wr_data),
      .reg_ack_out    (reg_ack_out),
      .reg_rd_data    (reg_rd_data),
      .rw_regs        (rw_regs),
      .done_in        (done_in),
      .busy_in        (busy_in)
`ifdef GENEVR_CSR_IRQ_EN
      ,
      .irq_out        (irq_out)
`endif
   );

   typedef struct {
      int                cyc;
      bit                ack;
      bit                chk;
      logic [31:0]       data;
      logic [32*NRW-1:0] rw;
      bit                irq;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   started = 0;

   // Reference model of the register map.
   logic [31:0]       m_rw[NRW];
   bit                m_sticky[NUM_CH];
   int                m_cnt[NUM_CH];
   logic [NUM_CH-1:0] m_mask;
   int                last_acc = -10;

   task automatic model_reset();
      for (int i = 0; i < NRW; i++) m_rw[i] = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         m_sticky[ch] = 0;
         m_cnt[ch]    = 0;
      end
      m_mask = '0;
   endtask

   function automatic logic [31:0] ref_read(int w, logic [NUM_CH-1:0] bz);
      if (w < NRW) return m_rw[w];
      if (w >= 32 && w < 32 + NUM_CH)
         return {30'b0, bz[w-32], m_sticky[w-32]};
      if (w >= 48 && w < 48 + NUM_CH) return 32'(m_cnt[w-48]);
`ifdef GENEVR_CSR_IRQ_EN
      if (w == 31) return 32'(m_mask);
`endif
      return 32'hDEADBEEF;
   endfunction

   // One bus cycle: drive inputs, compute the model outcome of the next
   // clock edge and queue it for the monitor.
   task automatic step(input bit rst, input bit req, input bit rd, input bit hit,
                       input int w, input logic [31:0] wd,
                       input logic [NUM_CH-1:0] dn, input logic [NUM_CH-1:0] bz);
      exp_t        x;
      int          e;
      bit          acc;
      bit          irqn;
      bit          w1c[NUM_CH];
      bit          clr[NUM_CH];
      logic [17:0] tag;
      @(negedge clk);
      tag = hit ? TAG : (TAG ^ 18'($urandom_range(1, 262143)));
      reset          = rst;
      reg_req_in     = req;
      reg_rd_wr_L_in = rd;
      reg_addr_in    = {tag, 6'(w), 2'b00};
      reg_wr_data    = wd;
      done_in        = dn;
      busy_in        = bz;
      started        = 1;
      e      = cyc + 1;
      x.cyc  = e;
      x.ack  = 0;
      x.chk  = 0;
      x.data = '0;
      irqn   = 0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         if (m_sticky[ch] && m_mask[ch]) irqn = 1;
         w1c[ch] = 0;
         clr[ch] = 0;
      end
      if (rst) begin
         model_reset();
         last_acc = -10;
         x.chk = 1;
         irqn  = 0;
      end else begin
         acc = req && hit && (e != last_acc + 1);
         if (acc) begin
            last_acc = e;
            x.ack = 1;
            if (rd) begin
               x.chk  = 1;
               x.data = ref_read(w, bz);
            end
         end else if (req && !hit && (e != last_acc + 1)) begin
            x.chk = 1;
         end
         if (acc && !rd) begin
            if (w < NRW) m_rw[w] = wd;
            if (w >= 32 && w < 32 + NUM_CH) w1c[w-32] = wd[0];
            if (w >= 48 && w < 48 + NUM_CH) clr[w-48] = 1;
`ifdef GENEVR_CSR_IRQ_EN
            if (w == 31) m_mask = wd[NUM_CH-1:0];
`endif
         end
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if (dn[ch]) m_sticky[ch] = 1;
            else if (w1c[ch]) m_sticky[ch] = 0;
            if (clr[ch]) m_cnt[ch] = dn[ch] ? 1 : 0;
            else if (dn[ch]) m_cnt[ch] = (m_cnt[ch] >= CMAX) ? CMAX : m_cnt[ch] + 1;
         end
      end
      x.irq = irqn;
      for (int i = 0; i < NRW; i++) x.rw[32*i +: 32] = m_rw[i];
      q.push_back(x);
   endtask

   task automatic idle(input int n, input logic [NUM_CH-1:0] dn, input logic [NUM_CH-1:0] bz);
      for (int i = 0; i < n; i++) step(0, 0, 1, 1, 0, 32'h0, dn, bz);
   endtask

   // Request plus the following ack cycle.
   task automatic xact(input bit rd, input int w, input logic [31:0] d,
                       input logic [NUM_CH-1:0] dn, input logic [NUM_CH-1:0] bz);
      step(0, 1, rd, 1, w, d, dn, bz);
      step(0, 0, 1, 1, 0, 32'h0, 3'b000, bz);
   endtask

   task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, got, exp);
      end
   endtask

   // Monitor: compares the DUT after every clock edge.
   always begin
      exp_t x;
      @(posedge clk);
      #1;
      cyc++;
      if (started) begin
         if (q.size() > 0 && q[0].cyc == cyc) begin
            x = q.pop_front();
            check32("ack", 32'(reg_ack_out), 32'(x.ack));
            if (x.chk) check32("rd_data", reg_rd_data, x.data);
            if (x.ack) begin
               checks++;
               if (rw_regs !== x.rw) begin
                  errors++;
                  $display("FAIL rw_regs cyc=%0d: got %h expected %h", cyc, rw_regs, x.rw);
               end
            end
`ifdef GENEVR_CSR_IRQ_EN
            check32("irq_out", 32'(irq_out), 32'(x.irq));
`endif
         end else if (q.size() > 0 && q[0].cyc < cyc) begin
            x = q.pop_front();
            checks++;
            errors++;
            $display("FAIL stale_entry cyc=%0d: got none expected cycle %0d", cyc, x.cyc);
         end else if (reg_ack_out === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack cyc=%0d: got 1 expected 0", cyc);
         end
      end
   end

   initial begin
      bit                req, rd, hit, rst;
      int                w;
      logic [NUM_CH-1:0] dn, bz;
      model_reset();
      for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 0, 32'h0, 3'b000, 3'b000);

      // Reset values.
      xact(1, 0, 0, 3'b000, 3'b000);
      xact(1, 32, 0, 3'b000, 3'b000);
      xact(1, 48, 0, 3'b000, 3'b000);

      // Control word write / read back.
      xact(0, 2, 32'h12345678, 3'b000, 3'b000);
      xact(1, 2, 0, 3'b000, 3'b000);

      // Channel 1 completions, status, counter and W1C.
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 1, 0, 32'h0, 3'b010, 3'b000);
         idle(1, 3'b000, 3'b000);
      end
      xact(1, 33, 0, 3'b000, 3'b000);
      xact(1, 33, 0, 3'b000, 3'b010);
      xact(1, 49, 0, 3'b000, 3'b000);
      xact(0, 33, 32'h1, 3'b000, 3'b000);
      xact(1, 33, 0, 3'b000, 3'b000);

      // Counter saturation and clear-with-increment.
      idle(20, 3'b001, 3'b000);
      xact(1, 48, 0, 3'b000, 3'b000);
      xact(0, 48, 32'hFFFF_FFFF, 3'b001, 3'b000);
      xact(1, 48, 0, 3'b000, 3'b000);

      // Tag miss and unmapped word.
      step(0, 1, 1, 0, 0, 32'h0, 3'b000, 3'b000);
      xact(1, 20, 0, 3'b000, 3'b000);
      xact(0, 20, 32'hCAFE_F00D, 3'b000, 3'b000);
      xact(1, 31, 0, 3'b000, 3'b000);

      // Reset while a request is presented: aborted, no ack.
      step(1, 1, 1, 1, 2, 32'h0, 3'b000, 3'b000);
      xact(1, 2, 0, 3'b000, 3'b000);

`ifdef GENEVR_CSR_IRQ_EN
      xact(0, 31, 32'h4, 3'b000, 3'b000);
      step(0, 0, 1, 1, 0, 32'h0, 3'b100, 3'b000);
      idle(2, 3'b000, 3'b000);
      xact(0, 34, 32'h1, 3'b000, 3'b000);
      idle(2, 3'b000, 3'b000);
`endif

      // Randomised traffic.
      for (int n = 0; n < 800; n++) begin
         rst = ($urandom_range(0, 199) == 0);
         req = ($urandom_range(0, 2) != 0);
         rd  = $urandom_range(0, 1) == 1;
         hit = ($urandom_range(0, 9) != 0);
         case ($urandom_range(0, 5))
            0: w = $urandom_range(0, NRW - 1);
            1: w = 32 + $urandom_range(0, NUM_CH - 1);
            2: w = 48 + $urandom_range(0, NUM_CH - 1);
            3: w = $urandom_range(0, 63);
            4: w = 31;
            default: w = 32 + $urandom_range(0, NUM_CH - 1);
         endcase
         for (int ch = 0; ch < NUM_CH; ch++) dn[ch] = ($urandom_range(0, 3) == 0);
         bz = NUM_CH'($urandom);
         step(rst, req, rd, hit, w, $urandom, dn, bz);
      end

      idle(3, 3'b000, 3'b000);
      @(posedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
